// File: rtl/ddp_pkg.sv
// Shared constants for the ddp merge arbiter: arbitration mode encodings,
// the default packet width and a helper that sizes the channel-index field.
package ddp_pkg;

    localparam int MODE_RR      = 0;
    localparam int MODE_PRIO    = 1;
    localparam int PACKET_W_DEF = 40;

    // Width of a channel index; never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ddp_fifo.sv
// Per-channel packet FIFO. Pointers wrap modulo FIFO_DEPTH (a power of two);
// the count carries one extra bit so that full and empty stay distinct.
// The head entry is presented combinationally on rd_data.
module ddp_fifo #(
    parameter int PACKET_W   = 40,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [PACKET_W-1:0]           wr_data,
    output logic [PACKET_W-1:0]           rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);

    localparam int              PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [PACKET_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    // Storage array; contents are don't-care until written, so it is not reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/ddp_merge_arb.sv
// N_CH-input packet merge: each channel buffers into its own ddp_fifo, and an
// arbiter (round-robin or fixed priority) feeds a single registered output
// stage with a valid/ready handshake. Ack_out depends only on registered FIFO
// occupancy and reset, never on Ack_in.
module ddp_merge_arb
    import ddp_pkg::*;
#(
    parameter int PACKET_W   = PACKET_W_DEF,
    parameter int N_CH       = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int MODE       = MODE_RR
) (
    input  logic                       CP,
    input  logic                       MR_N,
    input  logic [N_CH-1:0]            Send_in,
    output logic [N_CH-1:0]            Ack_out,
    input  logic [N_CH*PACKET_W-1:0]   PACKET_IN,
    output logic                       Send_out,
    input  logic                       Ack_in,
    output logic [PACKET_W-1:0]        PACKET_OUT,
    output logic [ch_width(N_CH)-1:0]  CH_OUT
);

    localparam int                CH_W     = ch_width(N_CH);
    localparam int                CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [N_CH-1:0]      push;
    logic [N_CH-1:0]      pop;
    logic [N_CH-1:0]      full;
    logic [N_CH-1:0]      empty;
    logic [PACKET_W-1:0]  head  [N_CH];
    logic [CNT_W-1:0]     count [N_CH];
    logic [CH_W-1:0]      last_grant;
    logic [CH_W-1:0]      grant_idx;
    logic [CH_W-1:0]      cand;
    logic                 grant_valid;
    logic                 out_free;

    // The output register can take a new packet when empty or being drained.
    assign out_free = !Send_out || Ack_in;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        // Ready is held low during reset so nothing is accepted into a clearing FIFO.
        assign Ack_out[i] = MR_N && (count[i] != FULL_CNT);
        // full mirrors the count test above; it keeps the FIFO safe from overrun.
        assign push[i]    = Send_in[i] && Ack_out[i] && !full[i];
        assign pop[i]     = out_free && grant_valid && (grant_idx == CH_W'(i));

        ddp_fifo #(
            .PACKET_W   (PACKET_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (CP),
            .rst_n   (MR_N),
            .push    (push[i]),
            .pop     (pop[i]),
            .wr_data (PACKET_IN[i*PACKET_W +: PACKET_W]),
            .rd_data (head[i]),
            .count   (count[i]),
            .full    (full[i]),
            .empty   (empty[i])
        );
    end

    // Arbitration: walk candidates from lowest to highest precedence so the
    // last non-empty hit is the winner. Round-robin starts just after
    // last_grant; priority mode starts at channel 0.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = N_CH; k >= 1; k--) begin
            if (MODE == MODE_PRIO)
                cand = CH_W'(k - 1);
            else
                cand = CH_W'((int'(last_grant) + k) % N_CH);
            if (!empty[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Output register and round-robin pointer; last_grant resets so channel 0 wins first.
    always_ff @(posedge CP or negedge MR_N) begin
        if (!MR_N) begin
            Send_out   <= 1'b0;
            PACKET_OUT <= '0;
            CH_OUT     <= '0;
            last_grant <= CH_W'(N_CH - 1);
        end else if (out_free) begin
            if (grant_valid) begin
                Send_out   <= 1'b1;
                PACKET_OUT <= head[grant_idx];
                CH_OUT     <= grant_idx;
                last_grant <= grant_idx;
            end else begin
                Send_out   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ddp_merge_arb.sv
// Bench for ddp_merge_arb: two instances (round-robin and fixed priority),
// 4 channels, 4-deep FIFOs. Accepted packets go into per-channel expected
// queues; a monitor pops and compares on every output handshake, and directed
// scenarios additionally queue the expected CH_OUT order.
module tb_ddp_merge_arb;

    localparam int PW  = 40;
    localparam int NC  = 4;
    localparam int DEP = 4;

    logic              clk = 1'b0;
    logic              mr_n;
    logic [NC-1:0]     send_in  [2];
    logic [NC-1:0]     ack_out  [2];
    logic [NC*PW-1:0]  pkt_in   [2];
    logic              send_out [2];
    logic              ack_in   [2];
    logic [PW-1:0]     pkt_out  [2];
    logic [1:0]        ch_out   [2];

    int                n_cmp = 0;
    int                n_err = 0;
    logic [PW-1:0]     exp_q  [2*NC][$];
    int                exp_ch [2][$];
    int                acc_cnt [2][NC];
    logic [PW-1:0]     bp [6];
    int                idx;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_out(input int d);
        int c = int'(ch_out[d]);
        logic [PW-1:0] e;
        if (exp_q[d*NC+c].size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL out_unexpected dut%0d: got ch%0d pkt %0h, expected no packet", d, c, pkt_out[d]);
        end else begin
            e = exp_q[d*NC+c].pop_front();
            chk($sformatf("out_pkt dut%0d ch%0d", d, c), 64'(pkt_out[d]), 64'(e));
        end
        if (exp_ch[d].size() > 0)
            chk($sformatf("out_ch dut%0d", d), 64'(c), 64'(exp_ch[d].pop_front()));
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ddp_merge_arb #(
            .PACKET_W   (PW),
            .N_CH       (NC),
            .FIFO_DEPTH (DEP),
            .MODE       (g)
        ) u_dut (
            .CP         (clk),
            .MR_N       (mr_n),
            .Send_in    (send_in[g]),
            .Ack_out    (ack_out[g]),
            .PACKET_IN  (pkt_in[g]),
            .Send_out   (send_out[g]),
            .Ack_in     (ack_in[g]),
            .PACKET_OUT (pkt_out[g]),
            .CH_OUT     (ch_out[g])
        );

        // Record input transfers and check output transfers, sampled mid-cycle.
        always @(negedge clk) begin
            if (mr_n) begin
                for (int c = 0; c < NC; c++) begin
                    if (send_in[g][c] && ack_out[g][c]) begin
                        exp_q[g*NC+c].push_back(pkt_in[g][c*PW +: PW]);
                        acc_cnt[g][c]++;
                    end
                end
                if (send_out[g] && ack_in[g]) check_out(g);
            end
        end
    end

    function automatic logic [PW-1:0] rnd_pkt();
        logic [63:0] t = {$urandom, $urandom};
        return t[PW-1:0];
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < 2*NC; i++) if (exp_q[i].size() != 0) return 1'b0;
        for (int d = 0; d < 2; d++) if (exp_ch[d].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        for (int i = 0; i < 2*NC; i++) exp_q[i].delete();
        for (int d = 0; d < 2; d++) begin
            exp_ch[d].delete();
            for (int c = 0; c < NC; c++) acc_cnt[d][c] = 0;
        end
    endtask

    task automatic do_reset();
        mr_n = 1'b0;
        clear_sb();
        step();
        step();
        mr_n = 1'b1;
    endtask

    task automatic drain(input string nm, input int budget);
        int k = 0;
        for (int d = 0; d < 2; d++) begin
            send_in[d] = '0;
            ack_in[d]  = 1'b1;
        end
        while (!all_empty() && k < budget) begin
            step();
            k++;
        end
        chk({nm, "_drained"}, 64'(all_empty()), 64'd1);
        chk({nm, "_idle0"}, 64'(send_out[0]), 64'd0);
        chk({nm, "_idle1"}, 64'(send_out[1]), 64'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mr_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            send_in[d] = '0;
            pkt_in[d]  = '0;
            ack_in[d]  = 1'b0;
        end
        clear_sb();
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_send_out%0d", d), 64'(send_out[d]), 64'd0);
            chk($sformatf("rst_pkt_out%0d", d),  64'(pkt_out[d]),  64'd0);
            chk($sformatf("rst_ch_out%0d", d),   64'(ch_out[d]),   64'd0);
            chk($sformatf("rst_ack_out%0d", d),  64'(ack_out[d]),  64'd0);
        end
        mr_n = 1'b1;
        #1;
        chk("rel_ack_out0", 64'(ack_out[0]), 64'hF);
        chk("rel_ack_out1", 64'(ack_out[1]), 64'hF);

        // Latency: packet on channel 1 accepted on the first edge after reset release
        do_reset();
        ack_in[0] = 1'b1;
        send_in[0] = 4'b0010;
        pkt_in[0] = '0;
        pkt_in[0][1*PW +: PW] = 40'h12345;
        step();
        send_in[0] = '0;
        chk("lat_accepted", 64'(acc_cnt[0][1]), 64'd1);
        chk("lat_send_t", 64'(send_out[0]), 64'd0);
        step();
        chk("lat_send_t1", 64'(send_out[0]), 64'd1);
        chk("lat_pkt", 64'(pkt_out[0]), 64'h12345);
        chk("lat_ch", 64'(ch_out[0]), 64'd1);
        drain("lat", 20);

        // Round-robin: every channel holds two packets, then full-rate drain
        do_reset();
        ack_in[0] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < NC; c++) pkt_in[0][c*PW +: PW] = rnd_pkt();
            send_in[0] = 4'hF;
            step();
        end
        send_in[0] = '0;
        step();
        for (int k = 0; k < 8; k++) exp_ch[0].push_back(k % NC);
        ack_in[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("rr_thruput%0d", k), 64'(send_out[0]), 64'd1);
            step();
        end
        chk("rr_done", 64'(send_out[0]), 64'd0);
        drain("rr", 20);

        // Fixed priority: channels 0 and 2 loaded with three packets each
        do_reset();
        ack_in[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < NC; c++) pkt_in[1][c*PW +: PW] = rnd_pkt();
            send_in[1] = 4'b0101;
            step();
        end
        send_in[1] = '0;
        step();
        chk("pr_acc0", 64'(acc_cnt[1][0]), 64'd3);
        chk("pr_acc2", 64'(acc_cnt[1][2]), 64'd3);
        foreach (exp_ch[1][i]) ;
        exp_ch[1].push_back(0); exp_ch[1].push_back(0); exp_ch[1].push_back(0);
        exp_ch[1].push_back(2); exp_ch[1].push_back(2); exp_ch[1].push_back(2);
        drain("pr", 30);

        // Backpressure on channel 0, then simultaneous push/pop on a full FIFO
        do_reset();
        ack_in[0] = 1'b0;
        for (int k = 0; k < 6; k++) bp[k] = rnd_pkt();
        idx = 0;
        for (int k = 0; k < 10; k++) begin
            send_in[0] = (idx < 6) ? 4'b0001 : 4'b0000;
            if (idx < 6) pkt_in[0][PW-1:0] = bp[idx];
            step();
            idx = acc_cnt[0][0];
        end
        chk("bp_accepted", 64'(acc_cnt[0][0]), 64'd5);
        chk("bp_ack0_low", 64'(ack_out[0][0]), 64'd0);
        chk("bp_send_out", 64'(send_out[0]), 64'd1);
        chk("bp_pkt_head", 64'(pkt_out[0]), 64'(bp[0]));
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("bp_pkt_stable%0d", k), 64'(pkt_out[0]), 64'(bp[0]));
        end
        ack_in[0] = 1'b1;
        chk("pp_ack_before", 64'(ack_out[0][0]), 64'd0);
        step();
        chk("pp_no_push", 64'(acc_cnt[0][0]), 64'd5);
        chk("pp_ack_after", 64'(ack_out[0][0]), 64'd1);
        step();
        chk("pp_push_next", 64'(acc_cnt[0][0]), 64'd6);
        send_in[0] = '0;
        drain("bp", 30);

        // Reset asserted with three packets buffered on channel 1
        ack_in[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pkt_in[0][1*PW +: PW] = rnd_pkt();
            send_in[0] = 4'b0010;
            step();
        end
        send_in[0] = '0;
        step();
        chk("mr_pre_send", 64'(send_out[0]), 64'd1);
        mr_n = 1'b0;
        #1;
        chk("mr_send_out", 64'(send_out[0]), 64'd0);
        chk("mr_pkt_out", 64'(pkt_out[0]), 64'd0);
        chk("mr_ack_out", 64'(ack_out[0]), 64'd0);
        clear_sb();
        step();
        step();
        mr_n = 1'b1;
        #1;
        chk("mr_rel_ack0", 64'(ack_out[0]), 64'hF);
        chk("mr_rel_ack1", 64'(ack_out[1]), 64'hF);
        ack_in[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("mr_no_stale%0d", k), 64'(send_out[0]), 64'd0);
        end

        // Randomized traffic on both instances
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int d = 0; d < 2; d++) begin
                send_in[d] = 4'($urandom);
                for (int c = 0; c < NC; c++) pkt_in[d][c*PW +: PW] = rnd_pkt();
                ack_in[d] = ($urandom_range(0, 3) != 0);
            end
            step();
        end
        drain("rand", 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
